// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_pkg
// Description : Shared AXI4-Lite response codes, master FSM states, defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_WR_ADDR_DATA = 3'd1;
    localparam logic [2:0] ST_WR_RESP      = 3'd2;
    localparam logic [2:0] ST_RD_ADDR      = 3'd3;
    localparam logic [2:0] ST_RD_DATA      = 3'd4;
    localparam logic [2:0] ST_RSP          = 3'd5;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage : axi_lite_pkg
`default_nettype wire

// File: rtl/m_axi_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : m_axi_lite_master
// Description : Single-outstanding AXI4-Lite initiator driven by a local
//               command/response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module m_axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                      m_axi_aclk,
    input  logic                      m_axi_areset,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_we,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    input  logic [2:0]                cmd_prot,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_we,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,

    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                m_axi_awport,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                m_axi_arport,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
            $error("m_axi_lite_master: DATA_WIDTH must be 32 or 64");
        end
    endgenerate

    logic [2:0]             r_state;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [STRB_WIDTH-1:0]  r_wstrb;
    logic [2:0]             r_prot;
    logic                   r_awvalid;
    logic                   r_wvalid;
    logic                   r_arvalid;
    logic                   r_aw_done;
    logic                   r_w_done;
    logic                   r_rsp_we;
    logic [DATA_WIDTH-1:0]  r_rsp_rdata;
    logic [1:0]             r_rsp_resp;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_fin;
    logic w_w_fin;

    assign w_aw_hs  = r_awvalid & m_axi_awready;
    assign w_w_hs   = r_wvalid & m_axi_wready;
    // AW and W may complete in either order or together.
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done | w_w_hs;

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_prot      <= PROT_DEFAULT;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_addr  <= cmd_addr;
                        r_wdata <= cmd_wdata;
                        r_wstrb <= cmd_wstrb;
                        r_prot  <= cmd_prot;
                        if (cmd_we) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= ST_WR_ADDR_DATA;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR_ADDR_DATA: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_state <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        r_rsp_resp  <= m_axi_bresp;
                        r_rsp_rdata <= '0;
                        r_rsp_we    <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RD_ADDR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        r_rsp_rdata <= m_axi_rdata;
                        r_rsp_resp  <= m_axi_rresp;
                        r_rsp_we    <= 1'b0;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = (r_state == ST_IDLE);
    assign rsp_valid     = (r_state == ST_RSP);
    assign rsp_we        = r_rsp_we;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;

    assign m_axi_awaddr  = r_addr;
    assign m_axi_awport  = r_prot;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = (r_state == ST_WR_RESP);
    assign m_axi_araddr  = r_addr;
    assign m_axi_arport  = r_prot;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = (r_state == ST_RD_DATA);

endmodule : m_axi_lite_master
`default_nettype wire
